mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache-line refill burst (power of two, >=2).
REQ-002 Parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-003 Ports clk input 1, sole clock, rising edge.
REQ-004 Port rst input 1, reset, asynchronous active-high.
REQ-005 Port i_req input 1, instruction-cache line-refill request, held until i_done.
REQ-006 Port i_addr input ADDR_W, instruction refill byte address.
REQ-007 Ports i_rvalid output 1 / i_rdata output 32 / i_widx output log2(LINE_WORDS), returned refill word, its index within line.
REQ-008 Port i_done output 1, one-cycle pulse, instruction transaction complete.
REQ-009 Ports d_req input 1 / d_we input 1 / d_addr input ADDR_W / d_wdata input 32, data-cache request: d_we=0 line refill, d_we=1 single-word write-through; held stable until d_done.
REQ-010 Ports d_rvalid output 1 / d_rdata output 32 / d_widx output log2(LINE_WORDS) / d_done output 1, data-side equivalents of REQ-007/008.
REQ-011 Ports mem_req output 1 / mem_we output 1 / mem_addr output ADDR_W / mem_wdata output 32, single main-memory word request.
REQ-012 Ports mem_ack input 1 / mem_rdata input 32, memory completes current word; mem_rdata valid with mem_ack on reads.
REQ-013 Port busy output 1, high whenever state is not IDLE; drives pipeline stall logic.

Function
REQ-014 States IDLE, READ, WRITE, DONE; encoding free.
REQ-015 IDLE: no request -> stay; any request -> grant one, latch owner, we, address, wdata, enter READ or WRITE next cycle.
REQ-016 Arbitration: single requester wins; both requesting -> round-robin, side not granted last wins; after reset last-granted = I, so D wins first tie.
REQ-017 Requests arriving while not IDLE are not sampled until next IDLE cycle.
REQ-018 READ: burst base = latched address with low log2(LINE_WORDS)+2 bits cleared; word counter starts 0.
REQ-019 READ: mem_req=1, mem_we=0, mem_addr=base+4*counter, held stable until mem_ack.
REQ-020 READ on mem_ack: owner's rvalid=1, rdata=mem_rdata, widx=counter, same cycle (combinational from mem_ack); counter increments.
REQ-021 mem_req deasserts for exactly one cycle after each mem_ack before next word is requested.
REQ-022 READ with mem_ack on counter=LINE_WORDS-1 -> DONE; counter wraps to 0.
REQ-023 WRITE: mem_req=1, mem_we=1, mem_addr=latched address (unaligned bits passed through), mem_wdata=latched wdata until mem_ack -> DONE.
REQ-024 DONE: owner's done=1 for one cycle, mem_req=0, last-granted updated to owner, next state IDLE; new grant earliest in following IDLE cycle.
REQ-025 Owner deasserting req mid-transaction does not abort; transaction completes, rvalid/done still issued.
REQ-026 mem_ack while mem_req=0 ignored.
REQ-027 No memory latency bound; READ/WRITE wait indefinitely for mem_ack.
REQ-028 Non-owner rvalid and done remain 0 throughout.
REQ-029 busy=1 from first cycle after grant through DONE inclusive.

Reset
REQ-030 rst asserted, any state including mid-burst: state IDLE, counter 0, last-granted I, all outputs 0 immediately without clock.
REQ-031 mem_ack arriving during or after reset for aborted transaction ignored; first post-reset cycle IDLE.

Verification
REQ-032 i_req=1, i_addr=0x0000_1234, mem_ack after 2 cycles each, rdata 0xA0..0xA3 -> mem_addr 0x1230,0x1234,0x1238,0x123C; i_rvalid x4 with widx 0..3; i_done one cycle after 4th ack.
REQ-033 i_req and d_req (d_we=0, d_addr=0x2000) same cycle after reset -> D served first, then I; next tie served D again only after I grant.
REQ-034 d_req, d_we=1, d_addr=0x0000_0104, d_wdata=0xDEADBEEF, mem_ack 3 cycles later -> one mem_req with mem_we=1, addr 0x104, data 0xDEADBEEF; d_done pulse; no d_rvalid.
REQ-035 rst pulse during word 2 of I refill -> mem_req, busy, i_rvalid fall immediately; no i_done; fresh d_req after reset starts at word 0.
REQ-036 mem_ack same cycle as grant (mem_req=0) and i_req dropped mid-burst -> stray ack ignored; burst completes with 4 rvalids and i_done.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master main-memory arbiter: instruction and data caches share one
// single-word memory port; refills run as LINE_WORDS-word bursts, data writes as single words.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          i_rvalid,
    output logic [31:0]                   i_rdata,
    output logic [$clog2(LINE_WORDS)-1:0] i_widx,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [31:0]                   d_wdata,
    output logic                          d_rvalid,
    output logic [31:0]                   d_rdata,
    output logic [$clog2(LINE_WORDS)-1:0] d_widx,
    output logic                          d_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic                          busy
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             stateReg, stateNext;
    logic               ownerDReg;   // 1: data side owns the current transaction
    logic               lastDReg;    // 1: data side was granted last
    logic [ADDR_W-1:0]  addrReg;
    logic [31:0]        wdataReg;
    logic [IDX_W-1:0]   cntReg;
    logic               gapReg;      // forces the one idle cycle after every read ack

    logic               anyReq;
    logic               grantD;
    logic               readBeat;
    logic [ADDR_W-1:0]  lineBase;
    logic [ADDR_W-1:0]  wordOff;

    assign anyReq   = i_req | d_req;
    // On a tie the side that did not win last time gets the port.
    assign grantD   = d_req & (~i_req | ~lastDReg);
    assign lineBase = {addrReg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign wordOff  = {{(ADDR_W-OFF_W){1'b0}}, cntReg, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg  <= IDLE;
            ownerDReg <= 1'b0;
            lastDReg  <= 1'b0;
            addrReg   <= '0;
            wdataReg  <= '0;
            cntReg    <= '0;
            gapReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            gapReg   <= readBeat;
            if (stateReg == IDLE && anyReq) begin
                ownerDReg <= grantD;
                addrReg   <= grantD ? d_addr : i_addr;
                wdataReg  <= d_wdata;
                cntReg    <= '0;
            end
            if (readBeat) begin
                cntReg <= cntReg + IDX_W'(1);
            end
            if (stateReg == DONE) begin
                lastDReg <= ownerDReg;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        readBeat  = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (anyReq) begin
                    stateNext = (grantD && d_we) ? WRITE : READ;
                end
            end
            READ: begin
                mem_req  = ~gapReg;
                mem_addr = lineBase | wordOff;
                if (!gapReg && mem_ack) begin
                    readBeat = 1'b1;
                    if (cntReg == LAST_WORD) begin
                        stateNext = DONE;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addrReg;
                mem_wdata = wdataReg;
                if (mem_ack) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                i_done    = ~ownerDReg;
                d_done    = ownerDReg;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Read data is forwarded straight from the memory port in the ack cycle.
    assign i_rvalid = readBeat & ~ownerDReg;
    assign d_rvalid = readBeat & ownerDReg;
    assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;
    assign i_widx   = i_rvalid ? cntReg : '0;
    assign d_widx   = d_rvalid ? cntReg : '0;
    assign busy     = (stateReg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory responder, event monitor and a
// transaction-level reference model of grant order and burst contents.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int LW = 4;
    localparam int AW = 32;
    localparam int IW = $clog2(LW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic [IW-1:0] i_widx;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic [IW-1:0] d_widx;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .i_widx(i_widx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_widx(d_widx), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    // ---------------- memory responder ----------------
    logic        autoMem = 1'b1;
    logic        ackAuto = 1'b0;
    logic        ackMan = 1'b0;
    logic [31:0] rdAuto = '0;
    logic [31:0] rdMan = '0;
    int          lat = 1;
    int          waitCnt = 0;
    bit          randLat = 0;
    logic [31:0] memArr [logic [31:0]];

    assign mem_ack   = autoMem ? ackAuto : ackMan;
    assign mem_rdata = autoMem ? rdAuto : rdMan;

    function automatic logic [31:0] memVal(input logic [AW-1:0] a);
        if (memArr.exists(a)) return memArr[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    initial forever begin
        @(posedge clk); #1;
        if (rst || !mem_req) begin
            ackAuto = 1'b0;
            waitCnt = 0;
        end else if (waitCnt >= lat) begin
            ackAuto = 1'b1;
            rdAuto  = memVal(mem_addr);
            waitCnt = 0;
            if (randLat) lat = $urandom_range(0, 3);
        end else begin
            ackAuto = 1'b0;
            waitCnt++;
        end
    end

    // ---------------- monitor ----------------
    typedef struct { bit we; logic [AW-1:0] addr; logic [31:0] wdata; int cyc; } acc_t;
    typedef struct { logic [IW-1:0] widx; logic [31:0] data; } beat_t;
    typedef struct { bit side; int cyc; } done_t;

    acc_t  memLog[$];
    beat_t iLog[$];
    beat_t dLog[$];
    done_t doneLog[$];
    int    cyc = 0;
    int    protoErr = 0;
    int    busyCycles = 0;
    bit    prevAck = 0;
    bit    holdPending = 0;
    logic [AW-1:0] holdAddr = '0;
    bit    holdWe = 0;

    initial forever begin
        acc_t  a;
        beat_t b;
        done_t d;
        @(negedge clk);
        cyc++;
        if (busy) busyCycles++;
        if (!rst) begin
            if (prevAck && mem_req) protoErr++;
            if (holdPending && !(mem_req && mem_addr == holdAddr && mem_we == holdWe)) protoErr++;
            if ((i_rvalid && d_rvalid) || (i_done && d_done)) protoErr++;
        end
        prevAck     = mem_req && mem_ack && !rst;
        holdPending = mem_req && !mem_ack && !rst;
        holdAddr    = mem_addr;
        holdWe      = mem_we;
        if (mem_req && mem_ack) begin
            a.we = mem_we; a.addr = mem_addr; a.wdata = mem_we ? mem_wdata : 32'h0; a.cyc = cyc;
            memLog.push_back(a);
        end
        if (i_rvalid) begin b.widx = i_widx; b.data = i_rdata; iLog.push_back(b); end
        if (d_rvalid) begin b.widx = d_widx; b.data = d_rdata; dLog.push_back(b); end
        if (i_done) begin d.side = 0; d.cyc = cyc; doneLog.push_back(d); end
        if (d_done) begin d.side = 1; d.cyc = cyc; doneLog.push_back(d); end
    end

    // ---------------- reference model ----------------
    acc_t  expMem[$];
    beat_t expI[$];
    beat_t expD[$];
    bit    expDone[$];
    bit    lastModel = 0;   // side granted last, 0 = instruction

    task automatic clear_all();
        memLog.delete(); iLog.delete(); dLog.delete(); doneLog.delete();
        expMem.delete(); expI.delete(); expD.delete(); expDone.delete();
        busyCycles = 0;
    endtask

    task automatic model_txn(input bit side, input bit we, input logic [AW-1:0] a, input logic [31:0] wd);
        acc_t  e;
        beat_t b;
        logic [AW-1:0] base;
        if (we) begin
            e.we = 1; e.addr = a; e.wdata = wd; e.cyc = 0;
            expMem.push_back(e);
        end else begin
            base = a - (a % (LW * 4));
            for (int k = 0; k < LW; k++) begin
                e.we = 0; e.addr = base + 4 * k; e.wdata = 0; e.cyc = 0;
                expMem.push_back(e);
                b.widx = IW'(k); b.data = memVal(e.addr);
                if (side) expD.push_back(b); else expI.push_back(b);
            end
        end
        expDone.push_back(side);
        lastModel = side;
    endtask

    task automatic model_round(input bit useI, input bit useD);
        bit first;
        if (useI && useD) begin
            first = ~lastModel;
            if (first) begin
                model_txn(1, d_we, d_addr, d_wdata);
                model_txn(0, 0, i_addr, 0);
            end else begin
                model_txn(0, 0, i_addr, 0);
                model_txn(1, d_we, d_addr, d_wdata);
            end
        end else if (useI) model_txn(0, 0, i_addr, 0);
        else if (useD) model_txn(1, d_we, d_addr, d_wdata);
    endtask

    // Holds each request until its done pulse, then drops it in the following idle cycle.
    task automatic run_requests(input bit useI, input bit useD, input int budget, output bit timedOut);
        bit iPend = useI;
        bit dPend = useD;
        int n = 0;
        @(posedge clk); #1;
        i_req = useI; d_req = useD;
        while ((iPend || dPend) && n < budget) begin
            @(negedge clk); n++;
            if (i_done) iPend = 0;
            if (d_done) dPend = 0;
            @(posedge clk); #1;
            if (!iPend) i_req = 0;
            if (!dPend) d_req = 0;
        end
        timedOut = iPend || dPend;
        i_req = 0; d_req = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; i_req = 1; d_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, mem_req, mem_we, i_rvalid, d_rvalid, i_done, d_done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000", {busy, mem_req, mem_we, i_rvalid, d_rvalid, i_done, d_done});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
        end
        i_req = 0; d_req = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_tie();
        bit to;
        lat = 1; randLat = 0;
        for (int r = 0; r < 2; r++) begin
            clear_all();
            i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; d_we = 0; d_wdata = 0;
            model_round(1, 1);
            run_requests(1, 1, 200, to);
            checks++;
            if (to) begin failures++; $display("FAIL tie_timeout round=%0d got=timeout exp=done", r); end
            checks++;
            if (doneLog.size() != 2) begin
                failures++; $display("FAIL tie_done_count round=%0d got=%0d exp=2", r, doneLog.size());
            end else begin
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (doneLog[k].side !== expDone[k]) begin
                        failures++; $display("FAIL tie_order round=%0d idx=%0d got=%0d exp=%0d", r, k, doneLog[k].side, expDone[k]);
                    end
                end
            end
            checks++;
            if (memLog.size() != expMem.size()) begin
                failures++; $display("FAIL tie_mem_count round=%0d got=%0d exp=%0d", r, memLog.size(), expMem.size());
            end else if (memLog[0].addr !== expMem[0].addr) begin
                failures++; $display("FAIL tie_first_addr round=%0d got=%h exp=%h", r, memLog[0].addr, expMem[0].addr);
            end
        end
    endtask

    task automatic test_refill();
        bit to;
        clear_all();
        lat = 2; randLat = 0;
        for (int k = 0; k < 4; k++) memArr[32'h0000_1230 + 4 * k] = 32'hA0 + k;
        i_addr = 32'h0000_1234;
        run_requests(1, 0, 200, to);
        checks++;
        if (to) begin failures++; $display("FAIL refill_timeout got=timeout exp=done"); end
        checks++;
        if (memLog.size() != 4 || iLog.size() != 4) begin
            failures++; $display("FAIL refill_count got=%0d/%0d exp=4/4", memLog.size(), iLog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (memLog[k].addr !== 32'h0000_1230 + 4 * k || memLog[k].we !== 0) begin
                    failures++; $display("FAIL refill_addr[%0d] got=%h exp=%h", k, memLog[k].addr, 32'h0000_1230 + 4 * k);
                end
                checks++;
                if (iLog[k].widx !== IW'(k) || iLog[k].data !== 32'hA0 + k) begin
                    failures++; $display("FAIL refill_beat[%0d] got=%0d/%h exp=%0d/%h", k, iLog[k].widx, iLog[k].data, k, 32'hA0 + k);
                end
            end
            checks++;
            if (doneLog.size() != 1 || doneLog[0].side !== 0 || doneLog[0].cyc != memLog[3].cyc + 1) begin
                failures++; $display("FAIL refill_done got=%0d entries exp=1 entry one cycle after last ack", doneLog.size());
            end
        end
        checks++;
        if (busyCycles != 4 * 2 + 8) begin failures++; $display("FAIL refill_busy got=%0d exp=%0d", busyCycles, 16); end
        checks++;
        if (dLog.size() != 0) begin failures++; $display("FAIL refill_d_rvalid got=%0d exp=0", dLog.size()); end
    endtask

    task automatic test_write();
        bit to;
        clear_all();
        lat = 3;
        d_we = 1; d_addr = 32'h0000_0104; d_wdata = 32'hDEAD_BEEF;
        run_requests(0, 1, 200, to);
        checks++;
        if (to) begin failures++; $display("FAIL write_timeout got=timeout exp=done"); end
        checks++;
        if (memLog.size() != 1) begin
            failures++; $display("FAIL write_count got=%0d exp=1", memLog.size());
        end else if (memLog[0].we !== 1 || memLog[0].addr !== 32'h104 || memLog[0].wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL write_bus got=%0d/%h/%h exp=1/104/deadbeef", memLog[0].we, memLog[0].addr, memLog[0].wdata);
        end
        checks++;
        if (dLog.size() != 0 || iLog.size() != 0) begin failures++; $display("FAIL write_rvalid got=%0d exp=0", dLog.size() + iLog.size()); end
        checks++;
        if (doneLog.size() != 1 || doneLog[0].side !== 1) begin failures++; $display("FAIL write_done got=%0d entries exp=1 data-side", doneLog.size()); end
        checks++;
        if (busyCycles != 5) begin failures++; $display("FAIL write_busy got=%0d exp=5", busyCycles); end
        d_we = 0;
    endtask

    task automatic test_reset_midburst();
        bit to;
        int n = 0;
        clear_all();
        lat = 1;
        i_addr = 32'h0000_3000;
        @(posedge clk); #1;
        i_req = 1;
        do begin @(negedge clk); n++; end while (!(mem_req && iLog.size() == 2) && n < 100);
        checks++;
        if (n >= 100) begin failures++; $display("FAIL rstmid_reach got=timeout exp=word2"); end
        #2;
        rst = 1; autoMem = 0; ackMan = 1; i_req = 0;
        #1;
        checks++;
        if ({mem_req, busy, i_rvalid, i_done} !== 4'b0) begin
            failures++; $display("FAIL rstmid_async got=%b exp=0000", {mem_req, busy, i_rvalid, i_done});
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 0 || mem_req !== 0) begin failures++; $display("FAIL rstmid_first_idle got=%b%b exp=00", busy, mem_req); end
        @(posedge clk); #1;
        autoMem = 1; ackMan = 0;
        checks++;
        if (doneLog.size() != 0) begin failures++; $display("FAIL rstmid_no_idone got=%0d exp=0", doneLog.size()); end
        clear_all();
        lastModel = 0;
        d_we = 0; d_addr = 32'h0000_4000;
        model_round(0, 1);
        run_requests(0, 1, 200, to);
        checks++;
        if (to) begin failures++; $display("FAIL rstmid_d_timeout got=timeout exp=done"); end
        checks++;
        if (memLog.size() != 4 || memLog[0].addr !== 32'h0000_4000) begin
            failures++; $display("FAIL rstmid_d_start got=%0d words exp=4 from 00004000", memLog.size());
        end
        checks++;
        if (dLog.size() != 4 || dLog[0].widx !== '0 || iLog.size() != 0 || doneLog.size() != 1) begin
            failures++; $display("FAIL rstmid_d_beats got=%0d/%0d/%0d exp=4/0/1", dLog.size(), iLog.size(), doneLog.size());
        end
    endtask

    task automatic test_stray_ack();
        bit seenDone = 0;
        int n = 0;
        clear_all();
        lastModel = 1;
        i_addr = 32'h0000_5678;
        model_round(1, 0);
        @(posedge clk); #1;
        i_req = 1; autoMem = 0; ackMan = 1; rdMan = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        ackMan = 0; lat = 1; autoMem = 1;
        while (!seenDone && n < 200) begin
            @(negedge clk); n++;
            if (i_done) seenDone = 1;
            @(posedge clk); #1;
            if (iLog.size() > 0) i_req = 0;
        end
        i_req = 0;
        checks++;
        if (!seenDone) begin failures++; $display("FAIL stray_timeout got=timeout exp=done"); end
        checks++;
        if (iLog.size() != 4 || memLog.size() != 4) begin
            failures++; $display("FAIL stray_count got=%0d/%0d exp=4/4", iLog.size(), memLog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (iLog[k].widx !== expI[k].widx || iLog[k].data !== expI[k].data || memLog[k].addr !== expMem[k].addr) begin
                    failures++; $display("FAIL stray_beat[%0d] got=%0d/%h@%h exp=%0d/%h@%h", k, iLog[k].widx, iLog[k].data,
                                         memLog[k].addr, expI[k].widx, expI[k].data, expMem[k].addr);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 0 || doneLog.size() != 1) begin failures++; $display("FAIL stray_regrant got=%b/%0d exp=0/1", busy, doneLog.size()); end
    endtask

    task automatic test_random();
        bit to;
        int pat;
        randLat = 1;
        lastModel = 0;   // the stray-ack scenario granted the instruction side last
        for (int r = 0; r < 30; r++) begin
            clear_all();
            pat = $urandom_range(0, 2);
            i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            model_round(pat != 1, pat != 0);
            run_requests(pat != 1, pat != 0, 400, to);
            checks++;
            if (to) begin failures++; $display("FAIL rand_timeout round=%0d got=timeout exp=done", r); end
            checks++;
            if (memLog.size() != expMem.size() || iLog.size() != expI.size() || dLog.size() != expD.size()
                || doneLog.size() != expDone.size()) begin
                failures++;
                $display("FAIL rand_counts round=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", r, memLog.size(), iLog.size(),
                         dLog.size(), doneLog.size(), expMem.size(), expI.size(), expD.size(), expDone.size());
            end else begin
                foreach (expMem[k]) begin
                    checks++;
                    if (memLog[k].we !== expMem[k].we || memLog[k].addr !== expMem[k].addr || memLog[k].wdata !== expMem[k].wdata) begin
                        failures++; $display("FAIL rand_mem round=%0d idx=%0d got=%0d/%h/%h exp=%0d/%h/%h", r, k, memLog[k].we,
                                             memLog[k].addr, memLog[k].wdata, expMem[k].we, expMem[k].addr, expMem[k].wdata);
                    end
                end
                foreach (expI[k]) begin
                    checks++;
                    if (iLog[k].widx !== expI[k].widx || iLog[k].data !== expI[k].data) begin
                        failures++; $display("FAIL rand_ibeat round=%0d idx=%0d got=%0d/%h exp=%0d/%h", r, k, iLog[k].widx, iLog[k].data, expI[k].widx, expI[k].data);
                    end
                end
                foreach (expD[k]) begin
                    checks++;
                    if (dLog[k].widx !== expD[k].widx || dLog[k].data !== expD[k].data) begin
                        failures++; $display("FAIL rand_dbeat round=%0d idx=%0d got=%0d/%h exp=%0d/%h", r, k, dLog[k].widx, dLog[k].data, expD[k].widx, expD[k].data);
                    end
                end
                foreach (expDone[k]) begin
                    checks++;
                    if (doneLog[k].side !== expDone[k]) begin
                        failures++; $display("FAIL rand_order round=%0d idx=%0d got=%0d exp=%0d", r, k, doneLog[k].side, expDone[k]);
                    end
                end
            end
        end
        randLat = 0;
        checks++;
        if (protoErr != 0) begin failures++; $display("FAIL protocol_violations got=%0d exp=0", protoErr); end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_refill();
        test_write();
        test_reset_midburst();
        test_stray_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
